// File: rtl/risc8x_fetch.sv
// risc8x instruction fetch: fixed-latency ROM stream -> prefetch FIFO -> variable-length instruction (1..MAXI words).
// First instruction 2 cycles after a request; requests stop while count+inflight reaches DEPTH, and pc_load flushes everything.
module risc8x_fetch #(
    parameter int              WORD    = 8,
    parameter int              ADDR    = 16,
    parameter int              MAXI    = 4,
    parameter int              DEPTH   = 4,
    parameter logic [ADDR-1:0] RST_VEC = '0,
    localparam int             SW      = (MAXI > 1) ? $clog2(MAXI) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [ADDR-1:0]      mem_addr,
    input  logic [WORD-1:0]      mem_data,
    output logic [WORD-1:0]      hd_word,
    input  logic [SW-1:0]        hd_size,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [MAXI*WORD-1:0] instr,
    output logic [ADDR-1:0]      instr_pc,
    output logic [SW-1:0]        instr_size,
    input  logic                 pc_load,
    input  logic [ADDR-1:0]      pc_target
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WORD-1:0] word;
        logic [ADDR-1:0] addr;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [ADDR-1:0] fetch_pc;
    logic [ADDR-1:0] req_addr;
    logic            inflight;
    logic            discard;

    logic            push;
    logic [CW-1:0]   need;
    logic [CW-1:0]   pop_n;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
        return PW'((32'(p) + 32'(n)) % DEPTH);
    endfunction

    // Registered count plus the outstanding word reserves space for data not yet returned.
    assign mem_req  = !rst && !pc_load && ((32'(count) + 32'(inflight)) < DEPTH);
    assign mem_addr = fetch_pc;

    // Data landing in a redirect or reset cycle belongs to the old stream.
    assign push  = inflight && !discard && !pc_load && !rst;
    assign need  = CW'(hd_size) + CW'(1);
    assign pop_n = (instr_valid && instr_ready) ? need : '0;

    always_comb begin
        instr       = '0;
        instr_pc    = '0;
        instr_size  = '0;
        hd_word     = '0;
        instr_valid = (count >= need);
        if (count != '0) begin
            hd_word = fifo_q[rd_ptr].word;
        end
        if (instr_valid) begin
            instr_pc   = fifo_q[rd_ptr].addr;
            instr_size = hd_size;
            for (int i = 0; i < MAXI; i++) begin
                if (i <= int'(hd_size)) begin
                    instr[i*WORD +: WORD] = fifo_q[ptr_add(rd_ptr, CW'(i))].word;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RST_VEC;
            req_addr <= RST_VEC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                req_addr <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR'(1);
            end
            if (pc_load) begin
                fetch_pc <= pc_target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= inflight;
            end else begin
                discard <= 1'b0;
                count   <= count + CW'(push) - pop_n;
                rd_ptr  <= ptr_add(rd_ptr, pop_n);
                if (push) begin
                    wr_ptr <= ptr_add(wr_ptr, CW'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{word: mem_data, addr: req_addr};
        end
    end

endmodule

// File: tb/tb_risc8x_fetch.sv
// Directed bench for risc8x_fetch: ROM model returns addr[7:0]^rom_xor, decoder length comes from len_tab.
module tb_risc8x_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  hd_word;
    logic [1:0]  hd_size;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic [1:0]  instr_size;
    logic        pc_load;
    logic [15:0] pc_target;

    logic [7:0]  rom_xor;
    logic [1:0]  len_tab [256];
    int          errors = 0;
    int          checks = 0;

    risc8x_fetch #(
        .WORD(8), .ADDR(16), .MAXI(4), .DEPTH(4), .RST_VEC(16'h0100)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .hd_word(hd_word), .hd_size(hd_size),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_size(instr_size),
        .pc_load(pc_load), .pc_target(pc_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous ROM.
    always @(posedge clk) mem_data <= mem_addr[7:0] ^ rom_xor;

    assign hd_size = len_tab[hd_word];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_load = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic next_instr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        do_reset();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL rst_mem_addr: got %h want 0100", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
        checks++; if (instr_size !== 2'd0) begin errors++; $display("FAIL rst_size: got %h want 0", instr_size); end
        checks++; if (hd_word !== 8'h0) begin errors++; $display("FAIL rst_hd_word: got %h want 0", hd_word); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL c0_req: got %b/%h want 1/0100", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL c0_valid: got %b want 0", instr_valid); end
        cyc();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b want 0", instr_valid); end
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 + 16'(k) || instr !== 32'(k)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, instr_valid, instr_pc, instr, 16'h0100 + 16'(k), 32'(k));
            end
        end
    endtask

    task automatic test_var_len();
        logic [31:0] exp_i [3];
        logic [15:0] exp_pc [3];
        logic [1:0]  exp_sz [3];
        bit          ok;
        exp_i  = '{32'hA3A2A1A0, 32'h000000A4, 32'h0000A6A5};
        exp_pc = '{16'h0100, 16'h0104, 16'h0105};
        exp_sz = '{2'd3, 2'd0, 2'd1};
        do_reset();
        rom_xor = 8'hA0;
        len_tab[8'hA0] = 2'd3;
        len_tab[8'hA5] = 2'd1;
        rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            next_instr(ok);
            checks++; if (!ok) begin errors++; $display("FAIL varlen_timeout_%0d: no instr_valid within 40 cycles", n); end
            checks++;
            if (instr !== exp_i[n] || instr_pc !== exp_pc[n] || instr_size !== exp_sz[n]) begin
                errors++;
                $display("FAIL varlen_%0d: got i=%h pc=%h sz=%0d want i=%h pc=%h sz=%0d", n, instr, instr_pc, instr_size, exp_i[n], exp_pc[n], exp_sz[n]);
            end
            cyc();
        end
        len_tab[8'hA0] = 2'd0;
        len_tab[8'hA5] = 2'd0;
    endtask

    task automatic test_backpressure();
        int nreq;
        bit ok;
        do_reset();
        rom_xor = 8'h00;
        instr_ready = 1'b0;
        rst = 1'b0;
        #1;
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req === 1'b1) begin
                checks++;
                if (mem_addr !== 16'h0100 + 16'(nreq)) begin errors++; $display("FAIL stall_addr_%0d: got %h want %h", nreq, mem_addr, 16'h0100 + 16'(nreq)); end
                nreq++;
            end
            cyc();
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL stall_nreq: got %0d want 4", nreq); end
        checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin errors++; $display("FAIL stall_hold: got req=%b v=%b pc=%h want 0/1/0100", mem_req, instr_valid, instr_pc); end
        instr_ready = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL resume_same_cycle: got %b want 0", mem_req); end
        cyc();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0104) begin errors++; $display("FAIL resume_req: got %b/%h want 1/0104", mem_req, mem_addr); end
        checks++; if (instr_pc !== 16'h0101) begin errors++; $display("FAIL resume_pc1: got %h want 0101", instr_pc); end
        cyc();
        for (int j = 2; j < 8; j++) begin
            next_instr(ok);
            checks++;
            if (!ok || instr_pc !== 16'h0100 + 16'(j) || instr !== 32'(j)) begin
                errors++;
                $display("FAIL resume_%0d: got ok=%b pc=%h i=%h want pc=%h i=%h", j, ok, instr_pc, instr, 16'h0100 + 16'(j), 32'(j));
            end
            cyc();
        end
    endtask

    task automatic test_pc_load();
        bit ok;
        do_reset();
        instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) cyc();
        pc_load = 1'b1;
        pc_target = 16'h0200;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_t_req: got %b want 0", mem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0102) begin errors++; $display("FAIL load_t_xfer: got v=%b pc=%h want 1/0102", instr_valid, instr_pc); end
        cyc();
        pc_load = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL load_t1_req: got %b/%h want 1/0200", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL load_t1_valid: got %b want 0", instr_valid); end
        cyc();
        checks++; if (instr_valid !== 1'b0 || hd_word !== 8'h00) begin errors++; $display("FAIL load_t2: got v=%b hd=%h want 0/00", instr_valid, hd_word); end
        cyc();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0200 || instr !== 32'h0) begin errors++; $display("FAIL load_t3: got v=%b pc=%h i=%h want 1/0200/0", instr_valid, instr_pc, instr); end
        cyc();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0201 || instr !== 32'h1) begin errors++; $display("FAIL load_t4: got v=%b pc=%h i=%h want 1/0201/1", instr_valid, instr_pc, instr); end
        pc_load = 1'b1;
        pc_target = 16'h0300;
        cyc();
        pc_target = 16'h0400;
        cyc();
        pc_load = 1'b0;
        #1;
        next_instr(ok);
        checks++; if (!ok || instr_pc !== 16'h0400 || instr !== 32'h0) begin errors++; $display("FAIL load_last_wins: got ok=%b pc=%h i=%h want 0400/0", ok, instr_pc, instr); end
        cyc();
    endtask

    task automatic test_wrap();
        bit ok;
        len_tab[8'hFE] = 2'd2;
        pc_load = 1'b1;
        pc_target = 16'hFFFE;
        cyc();
        pc_load = 1'b0;
        #1;
        next_instr(ok);
        checks++; if (!ok || instr_pc !== 16'hFFFE || instr !== 32'h0000FFFE || instr_size !== 2'd2) begin errors++; $display("FAIL wrap_instr: got ok=%b pc=%h i=%h sz=%0d want FFFE/0000FFFE/2", ok, instr_pc, instr, instr_size); end
        cyc();
        next_instr(ok);
        checks++; if (!ok || instr_pc !== 16'h0001 || instr !== 32'h1) begin errors++; $display("FAIL wrap_next: got ok=%b pc=%h i=%h want 0001/1", ok, instr_pc, instr); end
        cyc();
        len_tab[8'hFE] = 2'd0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        instr_ready = 1'b0;
        pc_load = 1'b1;
        pc_target = 16'h0310;
        cyc();
        pc_load = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0310 || hd_word !== 8'h10) begin errors++; $display("FAIL mid_prefill: got v=%b pc=%h hd=%h want 1/0310/10", instr_valid, instr_pc, hd_word); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", mem_req); end
        cyc();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0100 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 16'h0 || instr_size !== 2'd0 || hd_word !== 8'h0) begin
            errors++;
            $display("FAIL mid_rst_outputs: got req=%b addr=%h v=%b i=%h pc=%h sz=%0d hd=%h", mem_req, mem_addr, instr_valid, instr, instr_pc, instr_size, hd_word);
        end
        instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        next_instr(ok);
        checks++; if (!ok || instr_pc !== 16'h0100 || instr !== 32'h0) begin errors++; $display("FAIL mid_restart: got ok=%b pc=%h i=%h want 0100/0", ok, instr_pc, instr); end
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        pc_load = 1'b0;
        pc_target = 16'h0;
        instr_ready = 1'b0;
        rom_xor = 8'h00;
        for (int i = 0; i < 256; i++) len_tab[i] = 2'd0;
        test_reset();
        test_var_len();
        test_backpressure();
        test_pc_load();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
